// File: rtl/alu_req_sched.sv
// alu_req_sched: two-requester front end for the 8-bit serial ALU.
//
// Arbitrates round-robin between two requesters and runs one ALU operation
// at a time: start pulse + op code, three operand beats on alu_inbus,
// result capture from alu_outbus at fixed cycle offsets, a one-cycle ALU
// clear, then a held response to the owning requester.
//
// Ports:
//   CLK, RST            clock (rising edge), synchronous active-high reset
//   req_valid/req_ready per-requester request strobe / one-cycle accept pulse
//   req_op/req_x/req_y  per-requester op code and operands (packed by index)
//   resp_valid/ready    per-requester result handshake
//   resp_hi/resp_lo     result words (hi = 0 for add/sub)
//   busy                high whenever not idle
//   alu_*               ALU start/op/operand bus/result bus/reset pins
module alu_req_sched #(
    parameter int unsigned RES_ADD_CYC = 12,
    parameter int unsigned RES_MUL_CYC = 60
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [1:0]  req_valid,
    input  logic [3:0]  req_op,
    input  logic [15:0] req_x,
    input  logic [15:0] req_y,
    output logic [1:0]  req_ready,
    output logic [1:0]  resp_valid,
    input  logic [1:0]  resp_ready,
    output logic [7:0]  resp_hi,
    output logic [7:0]  resp_lo,
    output logic        busy,
    output logic        alu_begin,
    output logic [1:0]  alu_op,
    output logic [7:0]  alu_inbus,
    input  logic [7:0]  alu_outbus,
    output logic        alu_rst
);

    localparam logic [7:0] ADD_AT = 8'(RES_ADD_CYC);
    localparam logic [7:0] MUL_AT = 8'(RES_MUL_CYC);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_LOAD,
        S_WAIT,
        S_CAP_LO,
        S_CLEAR,
        S_RESP
    } state_t;

    state_t     state;
    logic [7:0] cnt;      // cycle offset from ISSUE (ISSUE = 0)
    logic       ptr;      // last granted requester
    logic       own;      // owner of the operation in flight
    logic [1:0] op;
    logic [7:0] x;
    logic [7:0] y;

    logic       gnt_any;
    logic       gnt_idx;

    // On a tie the requester other than the last winner is chosen.
    always_comb begin
        gnt_any = |req_valid;
        if (req_valid == 2'b11) begin
            gnt_idx = ~ptr;
        end else begin
            gnt_idx = req_valid[1];
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= S_IDLE;
            cnt     <= '0;
            ptr     <= 1'b1;
            own     <= 1'b0;
            op      <= '0;
            x       <= '0;
            y       <= '0;
            resp_hi <= '0;
            resp_lo <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (gnt_any) begin
                        own   <= gnt_idx;
                        ptr   <= gnt_idx;
                        op    <= req_op[{gnt_idx, 1'b0} +: 2];
                        x     <= req_x[{gnt_idx, 3'b000} +: 8];
                        y     <= req_y[{gnt_idx, 3'b000} +: 8];
                        cnt   <= '0;
                        state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    cnt   <= cnt + 8'd1;
                    state <= S_LOAD;
                end
                S_LOAD: begin
                    cnt <= cnt + 8'd1;
                    if (cnt == 8'd3) begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (!op[1] && cnt == ADD_AT) begin
                        resp_lo <= alu_outbus;
                        resp_hi <= '0;
                        state   <= S_CLEAR;
                    end else if (op[1] && cnt == MUL_AT) begin
                        resp_hi <= alu_outbus;
                        cnt     <= cnt + 8'd1;
                        state   <= S_CAP_LO;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                S_CAP_LO: begin
                    resp_lo <= alu_outbus;
                    state   <= S_CLEAR;
                end
                S_CLEAR: begin
                    state <= S_RESP;
                end
                S_RESP: begin
                    if (resp_ready[own]) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // The accept pulse must land in the IDLE cycle that samples the request
    // (one cycle before alu_begin), so it is decoded from the current state
    // and request lines rather than registered.
    always_comb begin
        req_ready = '0;
        if (state == S_IDLE && gnt_any && !RST) begin
            req_ready = gnt_idx ? 2'b10 : 2'b01;
        end
    end

    always_comb begin
        busy       = (state != S_IDLE);
        alu_begin  = (state == S_ISSUE);
        alu_rst    = RST || (state == S_CLEAR);
        alu_op     = '0;
        alu_inbus  = '0;
        resp_valid = '0;
        case (state)
            S_ISSUE, S_WAIT, S_CAP_LO, S_CLEAR: alu_op = op;
            S_LOAD: begin
                alu_op    = op;
                alu_inbus = (cnt == 8'd3) ? y : x;
            end
            S_RESP: resp_valid = own ? 2'b10 : 2'b01;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_alu_req_sched.sv
module tb_alu_req_sched;

    localparam int unsigned ADD_C = 12;
    localparam int unsigned MUL_C = 60;

    logic        CLK = 1'b0;
    logic        RST;
    logic [1:0]  req_valid;
    logic [3:0]  req_op;
    logic [15:0] req_x;
    logic [15:0] req_y;
    logic [1:0]  req_ready;
    logic [1:0]  resp_valid;
    logic [1:0]  resp_ready;
    logic [7:0]  resp_hi;
    logic [7:0]  resp_lo;
    logic        busy;
    logic        alu_begin;
    logic [1:0]  alu_op;
    logic [7:0]  alu_inbus;
    logic [7:0]  alu_outbus;
    logic        alu_rst;

    int n_cmp = 0;
    int n_err = 0;

    alu_req_sched #(.RES_ADD_CYC(ADD_C), .RES_MUL_CYC(MUL_C)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .req_valid  (req_valid),
        .req_op     (req_op),
        .req_x      (req_x),
        .req_y      (req_y),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_hi    (resp_hi),
        .resp_lo    (resp_lo),
        .busy       (busy),
        .alu_begin  (alu_begin),
        .alu_op     (alu_op),
        .alu_inbus  (alu_inbus),
        .alu_outbus (alu_outbus),
        .alu_rst    (alu_rst)
    );

    always #5 CLK = ~CLK;

    // Serial ALU stand-in: operands taken from the bus at offsets 1 and 3,
    // results presented only at the exact capture offsets, junk elsewhere.
    int unsigned m_off = 255;
    logic [1:0]  m_op = 2'b00;
    logic [7:0]  m_x = 8'h00;
    logic [7:0]  m_y = 8'h00;
    logic [15:0] m_prod;
    initial alu_outbus = 8'hEE;
    always @(posedge CLK) begin
        #1;
        if (alu_begin) begin
            m_off = 0;
            m_op  = alu_op;
        end else if (m_off < 255) begin
            m_off++;
        end
        if (m_off == 1) m_x = alu_inbus;
        if (m_off == 3) m_y = alu_inbus;
        alu_outbus = 8'hEE;
        if (!m_op[1] && m_off == ADD_C) begin
            alu_outbus = m_op[0] ? (m_x - m_y) : (m_x + m_y);
        end else if (m_op[1] && (m_off == MUL_C || m_off == MUL_C + 1)) begin
            if (!m_op[0]) m_prod = 16'(m_x) * 16'(m_y);
            else if (m_y == 8'h00) m_prod = 16'hFFFF;
            else m_prod = {m_x % m_y, m_x / m_y};
            alu_outbus = (m_off == MUL_C) ? m_prod[15:8] : m_prod[7:0];
        end
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_resp(output int n);
        n = 0;
        while (resp_valid == 2'b00 && n < 300) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        RST = 1'b1; req_valid = '0; resp_ready = '0;
        req_op = '0; req_x = '0; req_y = '0;
        tick(); tick();
        n_cmp++;
        if ({busy, alu_begin, alu_op, alu_inbus, req_ready, resp_valid, resp_hi, resp_lo} !== '0) begin
            n_err++;
            $display("FAIL reset_outs: got %b want all 0",
                     {busy, alu_begin, alu_op, alu_inbus, req_ready, resp_valid, resp_hi, resp_lo});
        end
        n_cmp++;
        if (alu_rst !== 1'b1) begin n_err++; $display("FAIL reset_alu_rst_hi: got %b want 1", alu_rst); end
        RST = 1'b0; #1;
        n_cmp++;
        if (alu_rst !== 1'b0) begin n_err++; $display("FAIL reset_alu_rst_lo: got %b want 0", alu_rst); end
    endtask

    task automatic test_add();
        req_op = 4'b0000; req_x = 16'h0023; req_y = 16'h0015; req_valid = 2'b01; #1;
        n_cmp++;
        if (req_ready !== 2'b01) begin n_err++; $display("FAIL add_ready: got %b want 01", req_ready); end
        tick(); req_valid = '0;
        n_cmp++;
        if ({alu_begin, alu_inbus} !== {1'b1, 8'h00}) begin
            n_err++; $display("FAIL add_issue: got begin=%b inbus=%h want 1/00", alu_begin, alu_inbus);
        end
        for (int unsigned k = 1; k <= 14; k++) begin
            tick();
            if (k == 1 || k == 2) begin
                n_cmp++;
                if (alu_inbus !== 8'h23) begin n_err++; $display("FAIL add_inbus_x%0d: got %h want 23", k, alu_inbus); end
            end
            if (k == 3) begin
                n_cmp++;
                if (alu_inbus !== 8'h15) begin n_err++; $display("FAIL add_inbus_y: got %h want 15", alu_inbus); end
            end
            if (k == 12) begin
                n_cmp++;
                if ({alu_rst, resp_valid} !== 3'b000) begin n_err++; $display("FAIL add_early: got rst/valid=%b want 000", {alu_rst, resp_valid}); end
            end
            if (k == 13) begin
                n_cmp++;
                if (alu_rst !== 1'b1) begin n_err++; $display("FAIL add_clear: got %b want 1", alu_rst); end
            end
        end
        n_cmp++;
        if ({alu_rst, resp_valid, resp_hi, resp_lo} !== {1'b0, 2'b01, 8'h00, 8'h38}) begin
            n_err++; $display("FAIL add_resp: got rst=%b v=%b hi=%h lo=%h want 0/01/00/38",
                              alu_rst, resp_valid, resp_hi, resp_lo);
        end
        resp_ready = 2'b01; tick(); resp_ready = '0;
        n_cmp++;
        if ({busy, resp_valid} !== 3'b000) begin n_err++; $display("FAIL add_done: got %b want 000", {busy, resp_valid}); end
    endtask

    task automatic test_muldiv(input logic [1:0] op, input logic [7:0] x, input logic [7:0] y,
                               input logic [7:0] hi, input logic [7:0] lo);
        int n;
        req_op = {op, 2'b00}; req_x = {x, 8'h00}; req_y = {y, 8'h00}; req_valid = 2'b10; #1;
        n_cmp++;
        if (req_ready !== 2'b10) begin n_err++; $display("FAIL md_ready op%0d: got %b want 10", op, req_ready); end
        tick(); req_valid = '0;
        wait_resp(n);
        n_cmp++;
        if (n !== MUL_C + 3) begin n_err++; $display("FAIL md_latency op%0d: got %0d want %0d", op, n, MUL_C + 3); end
        n_cmp++;
        if ({resp_valid, resp_hi, resp_lo} !== {2'b10, hi, lo}) begin
            n_err++; $display("FAIL md_resp op%0d: got v=%b hi=%h lo=%h want 10/%h/%h",
                              op, resp_valid, resp_hi, resp_lo, hi, lo);
        end
        resp_ready = 2'b10; tick(); resp_ready = '0;
    endtask

    task automatic test_sub();
        logic op_bad;
        op_bad = 1'b0;
        req_op = 4'b0001; req_x = 16'h0005; req_y = 16'h0009; req_valid = 2'b01; #1;
        tick(); req_valid = '0;
        for (int unsigned k = 0; k <= 13; k++) begin
            if (alu_op !== 2'b01) op_bad = 1'b1;
            tick();
        end
        n_cmp++;
        if (op_bad !== 1'b0) begin n_err++; $display("FAIL sub_op_held: got bad=%b want 0", op_bad); end
        n_cmp++;
        if ({alu_op, resp_valid, resp_hi, resp_lo} !== {2'b00, 2'b01, 8'h00, 8'hFC}) begin
            n_err++; $display("FAIL sub_resp: got op=%b v=%b hi=%h lo=%h want 00/01/00/FC",
                              alu_op, resp_valid, resp_hi, resp_lo);
        end
        resp_ready = 2'b01; tick(); resp_ready = '0;
    endtask

    task automatic test_tie();
        int n;
        int unsigned g;
        RST = 1'b1; tick(); RST = 1'b0;
        req_op = 4'b0000; req_x = 16'h1001; req_y = 16'h2002; req_valid = 2'b11; #1;
        for (int unsigned i = 0; i < 4; i++) begin
            g = i % 2;
            n_cmp++;
            if (req_ready !== (g == 1 ? 2'b10 : 2'b01)) begin
                n_err++; $display("FAIL tie_grant%0d: got %b want idx %0d", i, req_ready, g);
            end
            tick();
            wait_resp(n);
            n_cmp++;
            if ({resp_valid, resp_lo} !== {(g == 1 ? 2'b10 : 2'b01), (g == 1 ? 8'h30 : 8'h03)}) begin
                n_err++; $display("FAIL tie_resp%0d: got v=%b lo=%h want idx %0d", i, resp_valid, resp_lo, g);
            end
            resp_ready = resp_valid; tick(); resp_ready = '0; #1;
        end
        req_valid = '0;
    endtask

    task automatic test_backpressure();
        int n;
        req_op = 4'b0000; req_x = 16'h1107; req_y = 16'h2208; req_valid = 2'b11; #1;
        n_cmp++;
        if (req_ready !== 2'b01) begin n_err++; $display("FAIL bp_grant0: got %b want 01", req_ready); end
        tick();
        wait_resp(n);
        resp_ready = 2'b10;
        for (int unsigned k = 0; k < 10; k++) begin
            n_cmp++;
            if ({resp_valid, resp_hi, resp_lo, busy, req_ready} !== {2'b01, 8'h00, 8'h0F, 1'b1, 2'b00}) begin
                n_err++; $display("FAIL bp_hold%0d: got v=%b hi=%h lo=%h busy=%b rdy=%b want 01/00/0F/1/00",
                                  k, resp_valid, resp_hi, resp_lo, busy, req_ready);
            end
            tick();
        end
        resp_ready = 2'b01; #1;
        n_cmp++;
        if (req_ready !== 2'b00) begin n_err++; $display("FAIL bp_no_early_grant: got %b want 00", req_ready); end
        tick(); resp_ready = '0; #1;
        n_cmp++;
        if (req_ready !== 2'b10) begin n_err++; $display("FAIL bp_grant1: got %b want 10", req_ready); end
        tick(); req_valid = '0;
        wait_resp(n);
        n_cmp++;
        if ({resp_valid, resp_lo} !== {2'b10, 8'h33}) begin
            n_err++; $display("FAIL bp_resp1: got v=%b lo=%h want 10/33", resp_valid, resp_lo);
        end
        resp_ready = 2'b10; tick(); resp_ready = '0;
    endtask

    task automatic test_reset_mid();
        int n;
        req_op = 4'b0011; req_x = 16'h0064; req_y = 16'h0007; req_valid = 2'b01; #1;
        tick(); req_valid = '0;
        for (int unsigned k = 0; k < 30; k++) tick();
        RST = 1'b1; #1;
        n_cmp++;
        if ({busy, alu_rst} !== 2'b11) begin n_err++; $display("FAIL mid_rst_in: got busy/rst=%b want 11", {busy, alu_rst}); end
        tick(); RST = 1'b0; #1;
        n_cmp++;
        if ({busy, alu_begin, alu_op, alu_inbus, req_ready, resp_valid, resp_hi, resp_lo, alu_rst} !== '0) begin
            n_err++; $display("FAIL mid_rst_outs: got %b want all 0",
                              {busy, alu_begin, alu_op, alu_inbus, req_ready, resp_valid, resp_hi, resp_lo, alu_rst});
        end
        req_op = 4'b0000; req_x = 16'h0040; req_y = 16'h0002; req_valid = 2'b01; #1;
        n_cmp++;
        if (req_ready !== 2'b01) begin n_err++; $display("FAIL mid_regrant: got %b want 01", req_ready); end
        tick(); req_valid = '0;
        wait_resp(n);
        n_cmp++;
        if ({n[7:0], resp_valid, resp_hi, resp_lo} !== {8'(ADD_C + 2), 2'b01, 8'h00, 8'h42}) begin
            n_err++; $display("FAIL mid_fresh_resp: got n=%0d v=%b hi=%h lo=%h want %0d/01/00/42",
                              n, resp_valid, resp_hi, resp_lo, ADD_C + 2);
        end
        resp_ready = 2'b01; tick(); resp_ready = '0;
    endtask

    initial begin
        test_reset();
        test_add();
        test_muldiv(2'b10, 8'h0C, 8'h0A, 8'h00, 8'h78);
        test_muldiv(2'b10, 8'h30, 8'h0A, 8'h01, 8'hE0);
        test_muldiv(2'b11, 8'h64, 8'h07, 8'h02, 8'h0E);
        test_sub();
        test_tie();
        test_backpressure();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_req_sched.md
Name: alu_req_sched

Overview:
- Two-requester front end for the 8-bit serial ALU.
- Arbitrates round-robin between two operation requesters and sequences one ALU operation at a time.
- Per operation it issues the op code and a start pulse, streams the operands onto the ALU input bus, captures result word(s) from the ALU output bus at fixed cycle offsets, and returns the result to the owning requester.
- Sits between the processor-side requesters and the ALU start/op/inbus/outbus/reset pins.

Parameters:
RES_ADD_CYC, 12, cycle offset from the ISSUE cycle (offset 0) at which the add/sub result is valid on alu_outbus; legal range 5..254.
RES_MUL_CYC, 60, cycle offset at which the high word of a mul/div result is valid; low word follows at +1; legal range 5..253.

Ports:
CLK  in  1  single clock, rising edge.
RST  in  1  synchronous, active-high reset.
req_valid  in  2  request strobe, bit i = requester i.
req_op  in  4  op per requester, bits [2i+1:2i]: 00 add, 01 sub, 10 mul, 11 div.
req_x  in  16  first operand per requester, bits [8i+7:8i].
req_y  in  16  second operand per requester.
req_ready  out  2  one-cycle accept pulse to the granted requester.
resp_valid  out  2  result valid for requester i, held until accepted.
resp_ready  in  2  result accept from requester i.
resp_hi  out  8  result high word (A register); 0 for add/sub.
resp_lo  out  8  result low word (Q register for mul/div, sum/difference for add/sub).
busy  out  1  high in every state except IDLE.
alu_begin  out  1  ALU start pulse.
alu_op  out  2  ALU op code.
alu_inbus  out  8  ALU operand bus.
alu_outbus  in  8  ALU result bus.
alu_rst  out  1  ALU reset.

Behaviour:
- Reset (RST=1 at an edge): state IDLE, counter 0, RR pointer = 1 (requester 0 wins the next tie). All outputs 0 except alu_rst, which equals RST combinationally. A reset mid-operation discards the operation and any pending response; no resp_valid follows.
- States: IDLE, ISSUE, LOAD, WAIT, CAP_LO, CLEAR, RESP.
- IDLE:
  - If any req_valid is set, grant one requester. With both set, grant the requester other than the pointer, then set the pointer to the granted index.
  - req_ready[g]=1 for this single cycle.
  - Latch op, x, y and g.
  - Next state ISSUE.
  - A request withdrawn before grant has no effect.
- ISSUE (offset 0): alu_begin=1, alu_inbus=0. Counter cleared to 0, then increments every cycle until capture.
- LOAD: offsets 1 and 2 drive alu_inbus=x; offset 3 drives alu_inbus=y. Then WAIT.
- alu_inbus=0 in every other state.
- alu_op = latched op from ISSUE through CLEAR; 0 otherwise.
- WAIT:
  - add/sub: at offset RES_ADD_CYC, capture alu_outbus into resp_lo, clear resp_hi, go to CLEAR.
  - mul/div: at offset RES_MUL_CYC, capture alu_outbus into resp_hi, go to CAP_LO.
- CAP_LO (offset RES_MUL_CYC+1): capture alu_outbus into resp_lo, go to CLEAR.
- CLEAR: alu_rst=1 for exactly one cycle, returning the ALU to its start state. Next state RESP.
- RESP:
  - resp_valid[g]=1; resp_hi and resp_lo stable.
  - Leave on the cycle resp_ready[g]=1 and go to IDLE.
  - resp_ready on the non-owner index is ignored.
  - No new grant until IDLE, so minimum issue-to-issue spacing is offset(capture)+4 cycles.
- Simultaneous events:
  - resp_ready asserted together with new req_valid: the response completes, and the grant occurs in the following IDLE cycle.
  - A req_valid held through a busy period is served on return to IDLE.
- Counter is 8 bits and does not wrap inside legal parameter ranges.

Test Plan:
- Reset then single add: req0 op=00, x=0x23, y=0x15; ALU model returns 0x38 at offset 12 -> req_ready[0] at T0, alu_begin at T0+1, inbus 0x23,0x23,0x15 at offsets 1-3, alu_rst one cycle at offset 13, resp_valid[0] with hi=0x00, lo=0x38.
- Multiply on req1: x=0x0C, y=0x0A; model returns 0x00 at offset 60 and 0x78 at offset 61 -> resp_valid[1] with hi=0x00, lo=0x78; resp_valid[0] stays 0.
- Tie arbitration: both requesters valid continuously with add ops -> grant order 0,1,0,1; each response goes to the correct index.
- Backpressure: hold resp_ready[0]=0 for 10 cycles with req1 pending -> resp_valid[0] and data stable, busy=1, no req_ready[1] until the cycle after acceptance.
- Reset mid-operation: assert RST at offset 30 of a divide -> next cycle IDLE, all outputs 0, no resp_valid; a fresh req0 is granted immediately afterwards.
- Subtract x=0x05, y=0x09, model 0xFC -> lo=0xFC, hi=0x00, alu_op=01 held from ISSUE through CLEAR.
